// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: wide adder that time-shares one external 8-bit adder,
// one lane per cycle LSB first; the sum is published only on completion.
module adder_seq_ctrl #(
    parameter int BYTES = 4
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iStart,
    input  logic [8*BYTES-1:0] iData_a,
    input  logic [8*BYTES-1:0] iData_b,
    input  logic               iC,
    output logic [7:0]         oAdd_a,
    output logic [7:0]         oAdd_b,
    output logic               oAdd_c,
    input  logic [7:0]         iAdd_sum,
    input  logic               iAdd_c,
    output logic               oBusy,
    output logic               oDone,
    output logic [8*BYTES-1:0] oData,
    output logic               oData_C
);
    localparam int W  = 8 * BYTES;
    localparam int IW = $clog2(BYTES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateT;

    stateT         state;
    stateT         stateNext;
    logic [IW-1:0] idx;
    logic [W-1:0]  aReg;
    logic [W-1:0]  bReg;
    logic [W-1:0]  result;
    logic [W-1:0]  resultNext;
    logic          carry;
    logic          lastLane;

    assign lastLane = (idx == IW'(BYTES - 1));

    always_ff @(posedge iClk) begin
        if (iRst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        oBusy      = 1'b0;
        oDone      = 1'b0;
        oAdd_a     = '0;
        oAdd_b     = '0;
        oAdd_c     = 1'b0;
        resultNext = result;
        unique case (state)
            IDLE: begin
                if (iStart) stateNext = RUN;
            end
            RUN: begin
                oBusy  = 1'b1;
                oAdd_a = aReg[{idx, 3'b000} +: 8];
                oAdd_b = bReg[{idx, 3'b000} +: 8];
                oAdd_c = carry;
                resultNext[{idx, 3'b000} +: 8] = iAdd_sum;
                if (lastLane) stateNext = DONE;
            end
            DONE: begin
                oBusy     = 1'b1;
                oDone     = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // The last lane is merged in on the way to oData so no partial sum leaks out.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            idx     <= '0;
            carry   <= 1'b0;
            aReg    <= '0;
            bReg    <= '0;
            result  <= '0;
            oData   <= '0;
            oData_C <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (iStart) begin
                        aReg  <= iData_a;
                        bReg  <= iData_b;
                        carry <= iC;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    result <= resultNext;
                    carry  <= iAdd_c;
                    idx    <= idx + 1'b1;
                    if (lastLane) begin
                        oData   <= resultNext;
                        oData_C <= iAdd_c;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: scoreboard bench for the lane-serial wide adder with a
// behavioural 8-bit adder and a plain-arithmetic wide-sum reference.
module tb_adder_seq_ctrl;
    localparam int BYTES = 4;
    localparam int W     = 8 * BYTES;

    logic         iClk    = 1'b0;
    logic         iRst    = 1'b1;
    logic         iStart  = 1'b0;
    logic         iC      = 1'b0;
    logic [W-1:0] iData_a = '0;
    logic [W-1:0] iData_b = '0;
    logic [7:0]   oAdd_a;
    logic [7:0]   oAdd_b;
    logic         oAdd_c;
    logic [7:0]   iAdd_sum;
    logic         iAdd_c;
    logic         oBusy;
    logic         oDone;
    logic [W-1:0] oData;
    logic         oData_C;

    typedef struct {
        logic [W:0] sum;
        int         doneCyc;
    } expT;

    expT        sb[$];
    expT        monE;
    int         vecs = 0;
    int         errs = 0;
    int         cyc  = 0;
    logic [W:0] held = '0;

    adder_seq_ctrl #(.BYTES(BYTES)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iData_a (iData_a),
        .iData_b (iData_b),
        .iC      (iC),
        .oAdd_a  (oAdd_a),
        .oAdd_b  (oAdd_b),
        .oAdd_c  (oAdd_c),
        .iAdd_sum(iAdd_sum),
        .iAdd_c  (iAdd_c),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oData   (oData),
        .oData_C (oData_C)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    assign {iAdd_c, iAdd_sum} = 9'(oAdd_a) + 9'(oAdd_b) + 9'(oAdd_c);

    task automatic check(string name, logic [W:0] act, logic [W:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: every oDone pops the oldest expectation; oData must hold otherwise.
    always @(negedge iClk) begin
        if (!iRst) begin
            if (oDone) begin
                if (sb.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL spurious_done: got oDone=1, want 0 at cycle %0d", cyc);
                end else begin
                    monE = sb.pop_front();
                    check("sum", {oData_C, oData}, monE.sum);
                    check("latency", cyc, monE.doneCyc);
                    check("busy_in_done", oBusy, 1);
                    held = monE.sum;
                end
            end else begin
                check("hold", {oData_C, oData}, held);
            end
            if (!oBusy || oDone) check("adder_idle", {oAdd_a, oAdd_b, oAdd_c}, 0);
        end
    end

    task automatic startOp(logic [W-1:0] a, logic [W-1:0] b, logic c);
        expT e;
        iData_a = a;
        iData_b = b;
        iC      = c;
        iStart  = 1'b1;
        @(posedge iClk);
        #1;
        e.sum     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.doneCyc = cyc + BYTES;
        sb.push_back(e);
        iStart  = 1'b0;
        iData_a = $urandom;
        iData_b = $urandom;
        iC      = 1'($urandom_range(0, 1));
    endtask

    task automatic waitDone();
        int n = 0;
        while (sb.size() != 0 && n < 4 * BYTES) begin
            @(posedge iClk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            vecs++;
            errs++;
            $display("FAIL timeout: got %0d pending results, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic resetDut();
        iRst = 1'b1;
        @(posedge iClk);
        #1;
        held = '0;
        sb.delete();
        check("rst_busy", oBusy, 0);
        check("rst_done", oDone, 0);
        check("rst_data", {oData_C, oData}, 0);
        check("rst_adder", {oAdd_a, oAdd_b, oAdd_c}, 0);
        iRst = 1'b0;
    endtask

    initial begin
        iStart = 1'b1;
        resetDut();
        iStart = 1'b0;
        repeat (2) @(posedge iClk);
        #1;

        startOp('0, '0, 1'b0);
        waitDone();

        startOp(32'h0000_00FF, 32'h0000_0001, 1'b0);
        check("lane0_ops", {oAdd_a, oAdd_b, oAdd_c}, {8'hFF, 8'h01, 1'b0});
        @(posedge iClk);
        #1;
        check("lane1_ops", {oAdd_a, oAdd_b, oAdd_c}, {8'h00, 8'h00, 1'b1});
        waitDone();

        startOp(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        waitDone();

        startOp(32'h1234_5678, 32'h1111_1111, 1'b0);
        iStart = 1'b1;
        repeat (BYTES + 1) @(posedge iClk);
        #1;
        startOp(32'h8000_0000, 32'h8000_0000, 1'b1);
        waitDone();

        startOp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        @(posedge iClk);
        #1;
        resetDut();
        repeat (2 * BYTES) @(posedge iClk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            startOp($urandom, $urandom, 1'($urandom_range(0, 1)));
            waitDone();
        end

        repeat (3) @(posedge iClk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
